// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with configurable latency, lane decode and optional misalign check (DMEM_RESP_MISALIGN_EN)
`ifndef ENCDEC_BYTE
`define ENCDEC_BYTE 2'b00
`endif
`ifndef ENCDEC_HALF
`define ENCDEC_HALF 2'b01
`endif
`ifndef ENCDEC_WORD
`define ENCDEC_WORD 2'b10
`endif
module dmem_responder #(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [3:0]  req_writeb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_zero_ext,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] FIRST = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [1:0] a;
  logic accept, mis, pend_mis;
  logic [31:0] word, dec, pend_rdata;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign idx = req_addr[ADDR_W+1:2];
  assign a = req_addr[1:0];
  assign req_ready = state != WAIT;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign word = mem[idx];
`ifdef DMEM_RESP_MISALIGN_EN
  assign mis = (req_width == `ENCDEC_HALF && a == 2'b11) || (req_width == `ENCDEC_WORD && a != 2'b00);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    byte_v = word[{a, 3'b000} +: 8];
    half_v = a[1] ? word[31:16] : word[15:0];
    dec = (!req_read || mis) ? 32'd0 :
          (req_width == `ENCDEC_BYTE) ? {{24{!req_zero_ext && byte_v[7]}}, byte_v} :
          (req_width == `ENCDEC_HALF) ? {{16{!req_zero_ext && half_v[15]}}, half_v} : word;
  end
  // Array read above is combinational, so the accept-edge write below is seen only by later reads.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (accept && !mis && req_writeb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept) begin
      state_n = (LATENCY == 1) ? RESP : WAIT;
      cnt_n = FIRST;
    end else if (state == WAIT) begin
      state_n = (cnt == 4'd0) ? RESP : WAIT;
      cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      pend_rdata <= 32'd0;
      pend_mis <= 1'b0;
      resp_rdata <= 32'd0;
      resp_misalign <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        pend_rdata <= dec;
        pend_mis <= mis;
      end
      // Outputs update only when a response is presented and hold until the next one.
      if (accept && LATENCY == 1) begin
        resp_rdata <= dec;
        resp_misalign <= mis;
      end else if (state == WAIT && cnt == 4'd0) begin
        resp_rdata <= pend_rdata;
        resp_misalign <= pend_mis;
      end
    end
endmodule
